lut_layer_sched: RTL

//  Time-multiplexed evaluator for one LogicNets sparse layer: a single shared truth-table RAM
//  (OUT_WIDTH tables x 2^FAN_IN bits) plus per-neuron connection map replace OUT_WIDTH fixed
//  LUT neurons. Latches an input activation vector, evaluates neurons 0..OUT_WIDTH-1 one per

---
 rtl/lut_layer_pkg.sv | 13 +
 rtl/lut_tbl_ram.sv | 29 ++
 rtl/lut_layer_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lut_layer_pkg.sv
// rtl/lut_layer_pkg.sv - shared types and constants for the LUT layer scheduler
package lut_layer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic CFG_TABLE = 1'b0;
  localparam logic CFG_MAP   = 1'b1;

endpackage

// File: rtl/lut_tbl_ram.sv
// rtl/lut_tbl_ram.sv - 1W/1R distributed truth-table RAM with registered read
module lut_tbl_ram #(
  parameter int AW    = 12,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic          rdata_o
);

  (* ram_style = "distributed" *) logic mem_q [DEPTH];
  logic rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_layer_sched.sv
// rtl/lut_layer_sched.sv - time-multiplexed LogicNets sparse-layer evaluator
// One shared truth-table RAM plus a per-neuron connection map evaluate one neuron per cycle.
module lut_layer_sched
  import lut_layer_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter int FAN_IN    = 8,
  parameter int IDX_W     = $clog2(IN_WIDTH),
  parameter int NRN_W     = $clog2(OUT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [NRN_W-1:0]     cfg_nrn,
  input  logic [FAN_IN-1:0]    cfg_addr,
  input  logic [IDX_W-1:0]     cfg_wdata,
  output logic                 cfg_err,
  output logic                 busy
);

  localparam int               SLOT_W   = (FAN_IN > 1) ? $clog2(FAN_IN) : 1;
  localparam int               RAM_AW   = NRN_W + FAN_IN;
  localparam logic [NRN_W-1:0] LAST_NRN = NRN_W'(OUT_WIDTH - 1);
  localparam logic [31:0]      FAN_IN_U = 32'(FAN_IN);
  localparam logic [31:0]      IN_W_U   = 32'(IN_WIDTH);

  state_e                 state_q, state_d;
  logic [NRN_W-1:0]       nrn_q, nrn_d;
  logic                   drain_q;
  logic                   rd_vld_q;
  logic [NRN_W-1:0]       rd_nrn_q;
  logic [IN_WIDTH-1:0]    vec_q;
  logic [OUT_WIDTH-1:0]   out_q;
  logic                   cfg_err_q;
  logic [IDX_W-1:0]       map_q [OUT_WIDTH][FAN_IN];

  logic                   accept;
  logic                   cfg_idle;
  logic                   map_ok;
  logic                   tbl_we;
  logic                   map_we;
  logic                   cfg_reject;
  logic                   rd_en;
  logic [FAN_IN-1:0]      tbl_addr;
  logic                   ram_rdata;

  assign accept     = in_valid && (state_q == IDLE);
  assign cfg_idle   = cfg_we && (state_q == IDLE);
  assign map_ok     = (32'(cfg_addr) < FAN_IN_U) && (32'(cfg_wdata) < IN_W_U);
  assign tbl_we     = cfg_idle && (cfg_sel == CFG_TABLE);
  assign map_we     = cfg_idle && (cfg_sel == CFG_MAP) && map_ok;
  assign cfg_reject = cfg_we && ((state_q != IDLE) || ((cfg_sel == CFG_MAP) && !map_ok));
  // Reads stop once the last neuron is issued; the final cycle only drains the RAM output.
  assign rd_en      = (state_q == RUN) && !drain_q;

  always_comb begin
    tbl_addr = '0;
    for (int k = 0; k < FAN_IN; k++) begin
      tbl_addr[k] = vec_q[map_q[nrn_q][k]];
    end
  end

  always_comb begin
    state_d = state_q;
    nrn_d   = nrn_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          nrn_d   = '0;
        end
      end
      RUN: begin
        if (drain_q) begin
          state_d = DONE;
        end else if (nrn_q != LAST_NRN) begin
          nrn_d = nrn_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      nrn_q     <= '0;
      drain_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      out_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nrn_q     <= nrn_d;
      drain_q   <= rd_en && (nrn_q == LAST_NRN);
      rd_vld_q  <= rd_en;
      cfg_err_q <= cfg_reject;
      if (rd_vld_q) begin
        out_q[rd_nrn_q] <= ram_rdata;
      end
    end
  end

  // Datapath storage is intentionally unreset: tables and maps must be loaded before use.
  always_ff @(posedge clk) begin
    rd_nrn_q <= nrn_q;
    if (accept) begin
      vec_q <= in_data;
    end
    if (map_we) begin
      map_q[cfg_nrn][cfg_addr[SLOT_W-1:0]] <= cfg_wdata;
    end
  end

  lut_tbl_ram #(
    .AW    (RAM_AW),
    .DEPTH (OUT_WIDTH * (2 ** FAN_IN))
  ) u_tbl_ram (
    .clk_i   (clk),
    .we_i    (tbl_we),
    .waddr_i ({cfg_nrn, cfg_addr}),
    .wdata_i (cfg_wdata[0]),
    .re_i    (rd_en),
    .raddr_i ({nrn_q, tbl_addr}),
    .rdata_o (ram_rdata)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q != IDLE);

endmodule
